// File: rtl/io_mmio_pkg.sv
// Shared definitions for the memory-mapped I/O unit: register offsets, region select and TX state encoding.
// IO_BR_STATS_EN decides whether the branch-statistics offsets are decoded.
package io_mmio_pkg;

    localparam logic [1:0] IO_REGION    = 2'b10;

    localparam logic [7:0] IO_UART_CTRL = 8'h00;
    localparam logic [7:0] IO_UART_RX   = 8'h04;
    localparam logic [7:0] IO_UART_TX   = 8'h08;
    localparam logic [7:0] IO_CYC_CNT   = 8'h10;
    localparam logic [7:0] IO_INST_CNT  = 8'h14;
    localparam logic [7:0] IO_CNT_RST   = 8'h18;
    localparam logic [7:0] IO_BR_CNT    = 8'h1C;
    localparam logic [7:0] IO_BR_OK_CNT = 8'h20;

`ifdef IO_BR_STATS_EN
    localparam bit IO_BR_STATS = 1'b1;
`else
    localparam bit IO_BR_STATS = 1'b0;
`endif

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_FULL = 1'b1
    } tx_state_e;

    // True for every offset that maps to a register in this build.
    function automatic logic io_decoded(input logic [7:0] off);
        case (off)
            IO_UART_CTRL, IO_UART_RX, IO_UART_TX,
            IO_CYC_CNT, IO_INST_CNT, IO_CNT_RST: return 1'b1;
            IO_BR_CNT, IO_BR_OK_CNT:             return IO_BR_STATS;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/io_mmio_if.sv
// UART byte handshakes between the I/O unit (master side) and the UART (slave side).
interface io_mmio_if;

    logic       uart_tx_ready;
    logic       uart_tx_valid;
    logic [7:0] uart_tx_data;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_ready;

    modport master (
        output uart_tx_valid,
        output uart_tx_data,
        output uart_rx_ready,
        input  uart_tx_ready,
        input  uart_rx_valid,
        input  uart_rx_data
    );

    modport slave (
        input  uart_tx_valid,
        input  uart_tx_data,
        input  uart_rx_ready,
        output uart_tx_ready,
        output uart_rx_valid,
        output uart_rx_data
    );

endinterface

// File: rtl/io_mmio_counter.sv
// 32-bit wrapping event counter; clear takes priority over increment.
module io_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/io_mmio.sv
// Stage-3 memory-mapped I/O: one-byte UART TX/RX buffers plus cycle/instruction counters.
// Defining IO_BR_STATS_EN adds the branch and correct-branch counters with their ports.
module io_mmio
    import io_mmio_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        store_en,
    input  logic        load_en,
    input  logic        instr_retire,
    io_mmio_if.master   uart,
    output logic        stat_tx_ready,
    output logic        stat_rx_valid,
    output logic [7:0]  rx_byte,
    output logic [31:0] cyc_counter,
    output logic [31:0] instr_counter
`ifdef IO_BR_STATS_EN
    ,
    input  logic        br_resolve,
    input  logic        br_correct,
    output logic [31:0] br_counter,
    output logic [31:0] br_correct_counter
`endif
);

    if (CLK_HZ <= 0) begin : g_bad_clk_hz
        $error("io_mmio: CLK_HZ must be positive");
    end

    logic      io_hit;
    logic      tx_store;
    logic      rx_load;
    logic      cnt_clr;
    logic      unused_bits;

    tx_state_e tx_state_q;
    tx_state_e tx_state_d;
    logic [7:0] tx_data_q;
    logic [7:0] tx_data_d;

    logic       rx_full_q;
    logic       rx_full_d;
    logic [7:0] rx_byte_q;
    logic [7:0] rx_byte_d;

    // Only addr[31:30] and addr[7:0] take part in the decode; the rest is ignored.
    assign io_hit      = (addr[31:30] == IO_REGION) && io_decoded(addr[7:0]);
    assign tx_store    = store_en && io_hit && (addr[7:0] == IO_UART_TX);
    assign rx_load     = load_en  && io_hit && (addr[7:0] == IO_UART_RX);
    assign cnt_clr     = store_en && io_hit && (addr[7:0] == IO_CNT_RST);
    assign unused_bits = ^{addr[29:8], wdata[31:8]};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_store) begin
                    tx_state_d = TX_FULL;
                    tx_data_d  = wdata[7:0];
                end
            end
            TX_FULL: begin
                // Stores landing here are dropped, so the pending byte stays stable.
                if (uart.uart_tx_ready) begin
                    tx_state_d = TX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        rx_full_d = rx_full_q;
        rx_byte_d = rx_byte_q;
        if (!rx_full_q) begin
            if (uart.uart_rx_valid) begin
                rx_full_d = 1'b1;
                rx_byte_d = uart.uart_rx_data;
            end
        end else if (rx_load) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full_q <= 1'b0;
            rx_byte_q <= '0;
        end else begin
            rx_full_q <= rx_full_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    assign uart.uart_tx_valid = (tx_state_q == TX_FULL);
    assign uart.uart_tx_data  = tx_data_q;
    assign uart.uart_rx_ready = !rx_full_q;
    assign stat_tx_ready      = (tx_state_q == TX_IDLE);
    assign stat_rx_valid      = rx_full_q;
    assign rx_byte            = rx_byte_q;

    io_counter u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .clr   (cnt_clr),
        .count (cyc_counter)
    );

    io_counter u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_retire),
        .clr   (cnt_clr),
        .count (instr_counter)
    );

`ifdef IO_BR_STATS_EN
    io_counter u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_resolve),
        .clr   (cnt_clr),
        .count (br_counter)
    );

    io_counter u_br_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_resolve && br_correct),
        .clr   (cnt_clr),
        .count (br_correct_counter)
    );
`endif

endmodule
